// File: rtl/serial_subtractor_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// serial_subtractor_ctrl_pkg
// Shared definitions for the bit-serial subtractor controller.
//   state_t        : controller states (IDLE=0, RUN=1, DONE=2)
//   DEFAULT_WIDTH  : default operand/result width
//   cnt_width()    : width of the bit counter for a given operand width
// ---------------------------------------------------------------------------
package serial_subtractor_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // The counter only has to reach WIDTH-1; keep at least one bit so the
    // declaration stays legal for the smallest widths.
    function automatic int cnt_width(input int w);
        return ($clog2(w) < 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_subtractor_ctrl_cell.sv
// ---------------------------------------------------------------------------
// full_subtractor_1
// One-bit full subtractor cell: {bout, d} = ina - inb - bin.
//   ina  : minuend bit
//   inb  : subtrahend bit
//   bin  : borrow in
//   bout : borrow out
//   d    : difference bit
// ---------------------------------------------------------------------------
module full_subtractor_1 (
    input  logic ina,
    input  logic inb,
    input  logic bin,
    output logic bout,
    output logic d
);

    // A borrow is generated when the minuend bit is smaller than the
    // subtrahend bit, or propagated when the two bits are equal and a
    // borrow came in.
    always_comb begin
        d    = ina ^ inb ^ bin;
        bout = (~ina & inb) | (~(ina ^ inb) & bin);
    end

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// ---------------------------------------------------------------------------
// serial_subtractor_ctrl
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, computed LSB first
// through a single 1-bit full subtractor cell over WIDTH cycles.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   start : request, sampled only while not busy
//   a, b  : minuend / subtrahend, captured on an accepted start
//   bin   : initial borrow, captured on an accepted start
//   busy  : high while the operation runs
//   done  : one-cycle pulse, results valid
//   diff  : result register (held until the next completion)
//   bout  : final borrow (1 when a < b + bin, unsigned)
//   ovf   : signed overflow of a - b - bin
// ---------------------------------------------------------------------------
module serial_subtractor_ctrl
    import serial_subtractor_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             cell_d;
    logic             cell_bo;
    logic             accept;
    logic             last_bit;

    full_subtractor_1 u_cell (
        .ina  (a_sr[0]),
        .inb  (b_sr[0]),
        .bin  (borrow),
        .bout (cell_bo),
        .d    (cell_d)
    );

    // A request is only taken when no operation is running; in DONE this
    // gives back-to-back operation without passing through IDLE.
    assign accept   = start && (state != RUN);
    assign last_bit = (cnt == CW'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; busy and done are pure decodes of the state, so an
    // asynchronous reset clears them at once.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = accept ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, serial shifting and result registers.
    // On the last bit the operand shift registers still hold the operand
    // MSBs in bit 0, and the cell output is the result MSB, which is all
    // the overflow check needs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= bin;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
            res_sr <= {cell_d, res_sr[WIDTH-1:1]};
            borrow <= cell_bo;
            if (last_bit) begin
                cnt  <= '0;
                diff <= {cell_d, res_sr[WIDTH-1:1]};
                bout <= cell_bo;
                ovf  <= (a_sr[0] ^ b_sr[0]) & (a_sr[0] ^ cell_d);
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor_ctrl
// Directed, table-driven bench for serial_subtractor_ctrl at WIDTH=8,
// plus hand-written sequences for the multi-cycle corner cases.
// ---------------------------------------------------------------------------
module tb_serial_subtractor_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int checks;
    int errors;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
    } vec_t;

    vec_t vecs[7];

    serial_subtractor_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value and log a failure line when it differs.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Pulse start for one cycle with the given operands, then wait (bounded)
    // for done, counting the busy cycles seen before it.
    task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb,
                                 input logic tbin, output int busy_cnt,
                                 output logic got_done);
        busy_cnt = 0;
        got_done = 1'b0;
        @(negedge clk);
        a     = ta;
        b     = tb;
        bin   = tbin;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        int         bc;
        logic       gd;
        int         done_cnt;
        logic [7:0] diff_at_done;
        int         last_done;
        logic       idle_seen;
        logic       gap_ok;
        logic       diff_ok;

        checks = 0;
        errors = 0;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[5] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;

        #2;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_diff", 32'(diff), 32'd0);
        checkOutput("reset_bout", 32'(bout), 32'd0);
        checkOutput("reset_ovf",  32'(ovf),  32'd0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] table vectors");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].bin, bc, gd);
            checkOutput($sformatf("v%0d_done_seen", i), 32'(gd), 32'd1);
            checkOutput($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'd8);
            checkOutput($sformatf("v%0d_diff", i), 32'(diff), 32'(vecs[i].diff));
            checkOutput($sformatf("v%0d_bout", i), 32'(bout), 32'(vecs[i].bout));
            checkOutput($sformatf("v%0d_ovf", i),  32'(ovf),  32'(vecs[i].ovf));
            @(negedge clk);
            checkOutput($sformatf("v%0d_done_pulse_end", i), 32'(done), 32'd0);
            checkOutput($sformatf("v%0d_idle_busy", i), 32'(busy), 32'd0);
            checkOutput($sformatf("v%0d_diff_held", i), 32'(diff), 32'(vecs[i].diff));
        end

        // start pulsed during RUN with other operands must be ignored.
        $display("[TB] start during RUN");
        @(negedge clk);
        a = 8'h20; b = 8'h05; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_cnt     = 0;
        diff_at_done = 8'h00;
        for (int i = 0; i < 25; i++) begin
            if (i == 3) begin
                a = 8'h01; b = 8'h01; bin = 1'b1; start = 1'b1;
            end
            if (i == 4) start = 1'b0;
            if (done) begin
                done_cnt++;
                diff_at_done = diff;
            end
            @(negedge clk);
        end
        checkOutput("run_start_done_count", 32'(done_cnt), 32'd1);
        checkOutput("run_start_diff", 32'(diff_at_done), 32'h1B);

        // Reset in the 4th RUN cycle aborts the operation.
        $display("[TB] reset mid-run");
        applyStimulus(8'h7F, 8'hFF, 1'b0, bc, gd);
        checkOutput("pre_abort_ovf", 32'(ovf), 32'd1);
        @(negedge clk);
        a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_diff", 32'(diff), 32'd0);
        checkOutput("abort_bout", 32'(bout), 32'd0);
        checkOutput("abort_ovf",  32'(ovf),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt  = 0;
        idle_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (busy) idle_seen = 1'b1;
        end
        checkOutput("abort_no_done", 32'(done_cnt), 32'd0);
        checkOutput("abort_no_busy", 32'(idle_seen), 32'd0);

        // start held high: back-to-back operations every 9 cycles.
        $display("[TB] start held high");
        @(negedge clk);
        a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
        done_cnt  = 0;
        last_done = -1;
        idle_seen = 1'b0;
        gap_ok    = 1'b1;
        diff_ok   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy && !done) idle_seen = 1'b1;
            if (done) begin
                done_cnt++;
                if (diff !== 8'h0F) diff_ok = 1'b0;
                if (last_done >= 0 && (i - last_done) != 9) gap_ok = 1'b0;
                last_done = i;
            end
        end
        start = 1'b0;
        checkOutput("b2b_done_count", 32'(done_cnt), 32'd4);
        checkOutput("b2b_period", 32'(gap_ok), 32'd1);
        checkOutput("b2b_diff", 32'(diff_ok), 32'd1);
        checkOutput("b2b_no_idle", 32'(idle_seen), 32'd0);
        repeat (12) @(negedge clk);
        checkOutput("b2b_drained", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
